clk_div_bank: RTL and testbench

Parametrised bank of NCH independent programmable clock dividers/tick generators driven from the board clock. Each channel derives either a 50 %-duty divided clock or a one-cycle strobe from a runtime-writable divisor. It is the general replacement for fixed single-output dividers and serves the camera capture path (sensor XCLK, LED heartbeat, frame-rate ticks) from one block.

---
 rtl/clk_div_bank.sv | 89 ++++++++
 tb/tb_clk_div_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NCH programmable divided-clock / one-cycle tick generators.
// Define CLK_DIV_SHADOW_EN to defer divisor writes on running channels to the next terminal count.
module clk_div_bank #(
  parameter int NCH         = 3,
  parameter int CW          = 28,
  parameter int DEFAULT_DIV = 50000000,
  localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic [NCH-1:0] mode,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [CW-1:0]  wr_div,
  output logic           wr_ack,
  output logic           wr_err,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] clk_out
);
  localparam logic [CW-1:0] DEF = CW'(DEFAULT_DIV);
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [CW-1:0]  div_q [NCH];
  logic [CW-1:0]  div_d [NCH];
  logic [NCH-1:0] tick_q, tick_d, tog_q, tog_d, run, term, hit;
  logic           wr_ok, wr_ack_q, wr_err_q;
`ifdef CLK_DIV_SHADOW_EN
  logic [CW-1:0]  pend_q [NCH];
  logic [CW-1:0]  pend_d [NCH];
  logic [NCH-1:0] pnd_q, pnd_d, defer;
`endif
  assign wr_ok = wr_en && (int'(wr_ch) < NCH);
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hit[i]    = wr_ok && (int'(wr_ch) == i);
      run[i]    = en[i] && (div_q[i] != '0);
      term[i]   = run[i] && (cnt_q[i] == div_q[i] - CW'(1));
      tick_d[i] = term[i];
      tog_d[i]  = run[i] && (tog_q[i] ^ term[i]);
`ifdef CLK_DIV_SHADOW_EN
      // a write landing on the terminal edge or on an idle channel needs no deferral
      defer[i]  = hit[i] && run[i] && !term[i];
      cnt_d[i]  = (run[i] && !term[i]) ? cnt_q[i] + CW'(1) : '0;
      div_d[i]  = defer[i] ? div_q[i] :
                  hit[i] ? wr_div :
                  (pnd_q[i] && (term[i] || !run[i])) ? pend_q[i] : div_q[i];
      pend_d[i] = defer[i] ? wr_div : pend_q[i];
      pnd_d[i]  = defer[i] || (pnd_q[i] && !hit[i] && run[i] && !term[i]);
`else
      cnt_d[i]  = (run[i] && !term[i] && !hit[i]) ? cnt_q[i] + CW'(1) : '0;
      div_d[i]  = hit[i] ? wr_div : div_q[i];
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DEF;
`ifdef CLK_DIV_SHADOW_EN
        pend_q[i] <= DEF;
`endif
      end
`ifdef CLK_DIV_SHADOW_EN
      pnd_q    <= '0;
`endif
      tick_q   <= '0;
      tog_q    <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
`ifdef CLK_DIV_SHADOW_EN
      pend_q   <= pend_d;
      pnd_q    <= pnd_d;
`endif
      tick_q   <= tick_d;
      tog_q    <= tog_d;
      wr_ack_q <= wr_ok;
      wr_err_q <= wr_en && !wr_ok;
    end
  end
  assign tick    = tick_q;
  assign clk_out = (mode & tick_q) | (~mode & tog_q);
  assign wr_ack  = wr_ack_q;
  assign wr_err  = wr_err_q;
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed and randomized check of clk_div_bank against a timestamp-based reference model.
module tb_clk_div_bank;
  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DEF = 5;
`ifdef CLK_DIV_SHADOW_EN
  localparam logic [31:0] RETIME_MASK = 32'h54;
`else
  localparam logic [31:0] RETIME_MASK = 32'hAA;
`endif
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [1:0]     wr_ch = '0;
  logic [CW-1:0]  wr_div = '0;
  logic [NCH-1:0] en = '0;
  logic [NCH-1:0] mode = '0;
  logic           wr_ack, wr_err;
  logic [NCH-1:0] tick, clk_out;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  clk_div_bank #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_div(wr_div), .wr_ack(wr_ack), .wr_err(wr_err), .tick(tick), .clk_out(clk_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each channel remembers the edge number its current period began and ticks
  // exactly div edges later; the divided clock is the parity of ticks since the channel started.
  longint         n_edge;
  longint         m_start [NCH];
  int             m_div [NCH];
  int             m_pend [NCH];
  int             m_nt [NCH];
  bit             m_pnd [NCH];
  logic [NCH-1:0] m_tick;
  bit             e_ack, e_err, m_ok, m_run, m_hit;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_edge = 0;
      m_tick = '0;
      e_ack = 0;
      e_err = 0;
      for (int i = 0; i < NCH; i++) begin
        m_div[i] = DEF; m_pend[i] = DEF; m_pnd[i] = 0; m_start[i] = 0; m_nt[i] = 0;
      end
    end else begin
      n_edge++;
      m_ok = wr_en && (int'(wr_ch) < NCH);
      e_ack = m_ok;
      e_err = wr_en && !m_ok;
      for (int i = 0; i < NCH; i++) begin
        m_run = en[i] && (m_div[i] != 0);
        m_hit = m_ok && (int'(wr_ch) == i);
        if (!m_run) begin
          m_tick[i] = 1'b0; m_nt[i] = 0; m_start[i] = n_edge;
        end else begin
          m_tick[i] = (n_edge - m_start[i] == longint'(m_div[i]));
          if (m_tick[i]) begin m_nt[i]++; m_start[i] = n_edge; end
        end
`ifdef CLK_DIV_SHADOW_EN
        if (m_hit && m_run && !m_tick[i]) begin
          m_pend[i] = int'(wr_div); m_pnd[i] = 1;
        end else if (m_hit) begin
          m_div[i] = int'(wr_div); m_pnd[i] = 0;
        end else if (m_pnd[i] && (m_tick[i] || !m_run)) begin
          m_div[i] = m_pend[i]; m_pnd[i] = 0;
        end
`else
        if (m_hit) begin
          m_div[i] = int'(wr_div);
          if (m_run) m_start[i] = n_edge;
        end
`endif
      end
    end
  end

  logic [NCH-1:0] e_co;
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NCH; i++) e_co[i] = mode[i] ? m_tick[i] : (m_nt[i] % 2 == 1);
      chk("tick", 32'(tick), 32'(m_tick));
      chk("clk_out", 32'(clk_out), 32'(e_co));
      chk("wr_ack", 32'(wr_ack), 32'(e_ack));
      chk("wr_err", 32'(wr_err), 32'(e_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int ch, input int d);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_div = CW'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic record(input int ch, input int k, output logic [31:0] tm, output int hi);
    tm = '0;
    hi = 0;
    for (int j = 0; j < k; j++) begin
      @(posedge clk);
      #2;
      tm[j] = tick[ch];
      hi += int'(clk_out[ch]);
    end
  endtask

  task automatic wait_tick(input int ch, input bit need_hi);
    int j;
    for (j = 0; j < 40; j++) begin
      @(posedge clk);
      #2;
      if (tick[ch] && (!need_hi || clk_out[ch])) break;
    end
    if (j == 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_tick ch%0d: no tick within 40 cycles, required one", ch);
    end
  endtask

  initial begin
    logic [31:0] tm;
    int hi;
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1;
    chk("reset tick", 32'(tick), 0);
    chk("reset clk_out", 32'(clk_out), 0);
    chk("reset wr_ack", 32'(wr_ack), 0);
    rst = 1'b0;
    en = 3'b001;
    record(0, 20, tm, hi);
    chk("ch0 tick mask", tm, 32'h84210);
    chk("ch0 high cycles", 32'(hi), 10);
    chk("ch1/2 idle", 32'(tick[2:1] | clk_out[2:1]), 0);
    write(1, 3);
    chk("wr_ack after write", 32'(wr_ack), 1);
    chk("wr_err after good write", 32'(wr_err), 0);
    mode = 3'b010;
    en = 3'b011;
    record(1, 9, tm, hi);
    chk("ch1 pulse mask", tm, 32'h124);
    chk("ch1 pulse highs", 32'(hi), 3);
    write(3, 7);
    chk("wr_err invalid", 32'(wr_err), 1);
    chk("wr_ack invalid", 32'(wr_ack), 0);
    step();
    chk("wr_err one cycle", 32'(wr_err), 0);
    wait_tick(0, 0);
    step();
    write(0, 2);
    record(0, 8, tm, hi);
    chk("ch0 retime mask", tm, RETIME_MASK);
    write(2, 1);
    en = 3'b111;
    record(2, 6, tm, hi);
    chk("div1 tick mask", tm, 32'h3F);
    chk("div1 highs", 32'(hi), 3);
    write(2, 0);
    record(2, 5, tm, hi);
    chk("div0 tick mask", tm, 0);
    chk("div0 highs", 32'(hi), 0);
    write(0, 5);
    repeat (6) step();
    wait_tick(0, 1);
    repeat (3) step();
    chk("pre-reset clk_out0", 32'(clk_out[0]), 1);
    #1 rst = 1'b1;
    #1;
    chk("async rst tick", 32'(tick), 0);
    chk("async rst clk_out", 32'(clk_out), 0);
    step();
    step();
    rst = 1'b0;
    record(0, 5, tm, hi);
    chk("post-reset ch0 mask", tm, 32'h10);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) en = NCH'($urandom) | NCH'($urandom);
      if ($urandom_range(0, 7) == 0) mode = NCH'($urandom);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_ch = 2'($urandom_range(0, 3));
      wr_div = CW'($urandom_range(0, 9));
      step();
    end
    rst = 1'b0;
    wr_en = 1'b0;
    repeat (4) step();
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
